// File: rtl/mips_defines_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, funct codes,
// ALU operation codes, datapath select codes, FSM state encoding and the
// bundled control word passed from the decode table to the top level.
package mips_defines_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operation encodings
    localparam logic [2:0] ALU_OP_ADD = 3'b010;
    localparam logic [2:0] ALU_OP_SUB = 3'b110;
    localparam logic [2:0] ALU_OP_AND = 3'b000;
    localparam logic [2:0] ALU_OP_OR  = 3'b001;
    localparam logic [2:0] ALU_OP_SLT = 3'b111;
    localparam logic [2:0] ALU_OP_NOP = 3'b101;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU B operand select
    localparam logic [1:0] ALUSRCB_B      = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_EXEC     = 4'd6,
        ST_ALU_WB   = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_JUMP     = 4'd9,
        ST_HALT     = 4'd10
    } state_e;

    // Every datapath control produced by the decode table
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       illegal_instr;
    } ctrl_t;

    // True for the five supported R-type function codes
    function automatic logic funct_supported(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT);
    endfunction

    // True when opcode/funct form an instruction this controller can sequence
    function automatic logic instr_supported(input logic [5:0] opcode,
                                             input logic [5:0] funct);
        logic ok;
        ok = 1'b0;
        case (opcode)
            OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
            OP_RTYPE:                   ok = funct_supported(funct);
            default:                    ok = 1'b0;
        endcase
        return ok;
    endfunction

    // funct to ALU operation; unsupported codes fall back to NOP
    function automatic logic [2:0] funct_to_alu_op(input logic [5:0] funct);
        logic [2:0] op;
        op = ALU_OP_NOP;
        case (funct)
            FN_ADD:  op = ALU_OP_ADD;
            FN_SUB:  op = ALU_OP_SUB;
            FN_AND:  op = ALU_OP_AND;
            FN_OR:   op = ALU_OP_OR;
            FN_SLT:  op = ALU_OP_SLT;
            default: op = ALU_OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mod_ctrl_decode.sv
// Purpose: combinational state-to-control table for the multi-cycle MIPS FSM.
// Latency: purely combinational, zero cycles.
// Backpressure: none itself; FETCH strobes ir_write/pc_write only once mem_ready arrives.
module mod_ctrl_decode
    import mips_defines_pkg::*;
(
    input  state_e     state_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    // Start from the idle control word, then raise only what the state owns
    always_comb begin
        ctrl_o        = '0;
        ctrl_o.alu_op = ALU_OP_NOP;
        case (state_i)
            ST_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.iord      = 1'b0;
                ctrl_o.alu_src_a = 1'b0;
                ctrl_o.alu_src_b = ALUSRCB_FOUR;
                ctrl_o.alu_op    = ALU_OP_ADD;
                // IR and PC+4 are captured on the cycle the read completes
                if (mem_ready_i) begin
                    ctrl_o.ir_write  = 1'b1;
                    ctrl_o.pc_write  = 1'b1;
                    ctrl_o.pc_source = PCSRC_ALU;
                end
            end
            ST_DECODE: begin
                // Speculatively compute the branch target into ALUOut
                ctrl_o.alu_src_a     = 1'b0;
                ctrl_o.alu_src_b     = ALUSRCB_IMM_SH;
                ctrl_o.alu_op        = ALU_OP_ADD;
                ctrl_o.illegal_instr = !instr_supported(opcode_i, funct_i);
            end
            ST_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ALUSRCB_IMM;
                ctrl_o.alu_op    = ALU_OP_ADD;
            end
            ST_MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl_o.reg_dst    = 1'b0;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            ST_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ALUSRCB_B;
                ctrl_o.alu_op    = funct_to_alu_op(funct_i);
            end
            ST_ALU_WB: begin
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.mem_to_reg = 1'b0;
                ctrl_o.reg_write  = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = ALUSRCB_B;
                ctrl_o.alu_op        = ALU_OP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            default: begin
                // HALT and unused encodings keep the idle word
            end
        endcase
    end

endmodule

// File: rtl/mod_multicycle_ctrl.sv
// Purpose: Moore sequencer for the multi-cycle MIPS datapath with retire counter and bus timeout.
// Latency: lw 5, sw 4, R-type 4, beq 3, j 3 cycles at zero memory wait.
// Backpressure: memory states hold their request until mem_ready; WAIT_MAX idle cycles -> bus_err, HALT.
module mod_multicycle_ctrl
    import mips_defines_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero_flag,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             illegal_instr,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
);

    localparam int WCW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_MAX - 1);

    state_e           state_q, state_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             bus_err_q, bus_err_d;
    logic             retire;
    logic             wait_state;
    logic             timeout;
    ctrl_t            ctrl;

    // The branch decision is made in the datapath via pc_write_cond
    logic unused_zero_flag;
    assign unused_zero_flag = zero_flag;

    // Memory-facing states wait on mem_ready; the last permitted idle cycle
    // without mem_ready is the timeout, a late mem_ready still succeeds
    assign wait_state = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) ||
                        (state_q == ST_MEM_WR);
    assign timeout    = wait_state && !mem_ready && (wait_cnt_q == WAIT_LAST);

    // Next-state selection and retirement strobe
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                    OP_RTYPE:     state_d = funct_supported(funct) ? ST_EXEC : ST_FETCH;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    default:      state_d = ST_FETCH;
                endcase
            end
            ST_MEM_ADDR: begin
                state_d = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                if (mem_ready) state_d = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            ST_MEM_WR: begin
                if (mem_ready) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
            end
            ST_EXEC: begin
                state_d = ST_ALU_WB;
            end
            ST_ALU_WB, ST_BRANCH, ST_JUMP: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
        if (timeout) state_d = ST_HALT;
    end

    // Wait counter, sticky bus error and wrapping retire count
    always_comb begin
        wait_cnt_d = '0;
        if (wait_state && !mem_ready && !timeout) wait_cnt_d = wait_cnt_q + 1'b1;
        bus_err_d = bus_err_q | timeout;
        retired_d = retired_q + CNT_W'(retire);
    end

    // State and counter registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            wait_cnt_q <= '0;
            retired_q  <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            retired_q  <= retired_d;
            bus_err_q  <= bus_err_d;
        end
    end

    mod_ctrl_decode u_decode (
        .state_i     (state_q),
        .opcode_i    (opcode),
        .funct_i     (funct),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign pc_source     = ctrl.pc_source;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign illegal_instr = ctrl.illegal_instr;
    assign bus_err       = bus_err_q;
    assign retired       = retired_q;

endmodule

// File: tb/tb_mod_multicycle_ctrl.sv
// Directed bench for the multi-cycle MIPS controller: per-cycle control words
// are compared against hand-written expected vectors for each state.
module tb_mod_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero_flag;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic        reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_instr, bus_err;
    logic [1:0]  pc_source, alu_src_b;
    logic [2:0]  alu_op;
    logic [31:0] retired;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mod_multicycle_ctrl #(.WAIT_MAX(15), .CNT_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct         (funct),
        .zero_flag     (zero_flag),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .illegal_instr (illegal_instr),
        .bus_err       (bus_err),
        .retired       (retired)
    );

    // Observed control word, fields in a fixed order
    logic [17:0] obs;
    assign obs = {pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
                  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal_instr};

    function automatic logic [17:0] mk(input bit pcw, input bit pcwc, input bit [1:0] pcs,
                                       input bit io, input bit mr, input bit mw, input bit irw,
                                       input bit rd, input bit m2r, input bit rw, input bit asa,
                                       input bit [1:0] asb, input bit [2:0] aop, input bit ill);
        return {pcw, pcwc, pcs, io, mr, mw, irw, rd, m2r, rw, asa, asb, aop, ill};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply mem_ready for the current cycle, compare the control word, advance
    task automatic cyc(input string tag, input logic mr, input logic [17:0] ev);
        mem_ready = mr;
        #1;
        check_eq(tag, {14'd0, obs}, {14'd0, ev});
        tick();
    endtask

    logic [17:0] V_IDLE, V_FETCH_W, V_FETCH_R, V_DEC, V_DEC_ILL, V_MADDR, V_MRD, V_MWB;
    logic [17:0] V_MWR, V_ALUWB, V_BRANCH, V_JUMP;
    logic [5:0]  fn_tab [5];
    logic [2:0]  op_tab [5];

    initial begin
        //            pcw pcwc pcs  io mr mw irw rd m2r rw asa asb    aop     ill
        V_IDLE    = mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 3'b101, 0);
        V_FETCH_W = mk(0, 0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd1, 3'b010, 0);
        V_FETCH_R = mk(1, 0, 2'd0, 0, 1, 0, 1, 0, 0, 0, 0, 2'd1, 3'b010, 0);
        V_DEC     = mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 3'b010, 0);
        V_DEC_ILL = mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 3'b010, 1);
        V_MADDR   = mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 3'b010, 0);
        V_MRD     = mk(0, 0, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 3'b101, 0);
        V_MWB     = mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 3'b101, 0);
        V_MWR     = mk(0, 0, 2'd0, 1, 0, 1, 0, 0, 0, 0, 0, 2'd0, 3'b101, 0);
        V_ALUWB   = mk(0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 1, 0, 2'd0, 3'b101, 0);
        V_BRANCH  = mk(0, 1, 2'd1, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 3'b110, 0);
        V_JUMP    = mk(1, 0, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 3'b101, 0);
        fn_tab = '{6'h20, 6'h2A, 6'h22, 6'h24, 6'h25};
        op_tab = '{3'b010, 3'b111, 3'b110, 3'b000, 3'b001};

        rst_n = 1'b0; opcode = 6'h00; funct = 6'h00; zero_flag = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        #1;
        check_eq("rst_retired", retired, 32'd0);
        check_eq("rst_bus_err", {31'd0, bus_err}, 32'd0);
        cyc("rst_fetch", 1'b0, V_FETCH_W);

        // lw 0x8C220004
        opcode = 6'h23; funct = 6'h04;
        cyc("lw_fetch", 1'b1, V_FETCH_R);
        cyc("lw_dec", 1'b0, V_DEC);
        cyc("lw_addr", 1'b0, V_MADDR);
        cyc("lw_rd", 1'b1, V_MRD);
        check_eq("lw_ret_before", retired, 32'd0);
        cyc("lw_wb", 1'b0, V_MWB);
        check_eq("lw_ret_after", retired, 32'd1);

        // R-type: add, slt, sub, and, or
        opcode = 6'h00;
        for (int i = 0; i < 5; i++) begin
            funct = fn_tab[i];
            cyc($sformatf("r%0d_fetch", i), 1'b1, V_FETCH_R);
            cyc($sformatf("r%0d_dec", i), 1'b0, V_DEC);
            cyc($sformatf("r%0d_exec", i), 1'b0,
                mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, op_tab[i], 0));
            cyc($sformatf("r%0d_wb", i), 1'b0, V_ALUWB);
        end
        check_eq("rtype_retired", retired, 32'd6);

        // beq taken and not taken look identical to the controller
        opcode = 6'h04; funct = 6'h00;
        for (int z = 1; z >= 0; z--) begin
            zero_flag = z[0];
            cyc($sformatf("beq%0d_fetch", z), 1'b1, V_FETCH_R);
            cyc($sformatf("beq%0d_dec", z), 1'b0, V_DEC);
            cyc($sformatf("beq%0d_br", z), 1'b0, V_BRANCH);
        end
        check_eq("beq_retired", retired, 32'd8);

        // j, with mem_ready asserted outside memory states (ignored)
        opcode = 6'h02;
        cyc("j_fetch", 1'b1, V_FETCH_R);
        cyc("j_dec", 1'b1, V_DEC);
        cyc("j_jump", 1'b1, V_JUMP);
        check_eq("j_retired", retired, 32'd9);

        // sw with three wait cycles
        opcode = 6'h2B;
        cyc("sw_fetch", 1'b1, V_FETCH_R);
        cyc("sw_dec", 1'b0, V_DEC);
        cyc("sw_addr", 1'b0, V_MADDR);
        for (int w = 0; w < 3; w++) cyc($sformatf("sw_wait%0d", w), 1'b0, V_MWR);
        check_eq("sw_ret_before", retired, 32'd9);
        cyc("sw_done", 1'b1, V_MWR);
        check_eq("sw_ret_after", retired, 32'd10);

        // Illegal opcode 0x3F, then illegal R-type funct 0x21
        opcode = 6'h3F;
        cyc("ill_fetch", 1'b1, V_FETCH_R);
        cyc("ill_dec", 1'b0, V_DEC_ILL);
        cyc("ill_back", 1'b0, V_FETCH_W);
        opcode = 6'h00; funct = 6'h21;
        cyc("illf_fetch", 1'b1, V_FETCH_R);
        cyc("illf_dec", 1'b0, V_DEC_ILL);
        check_eq("ill_retired", retired, 32'd10);

        // 14 idle cycles then mem_ready on the 15th: still a successful fetch
        opcode = 6'h02;
        for (int w = 0; w < 14; w++) cyc($sformatf("late_w%0d", w), 1'b0, V_FETCH_W);
        cyc("late_fetch", 1'b1, V_FETCH_R);
        check_eq("late_bus_err", {31'd0, bus_err}, 32'd0);
        cyc("late_dec", 1'b0, V_DEC);
        cyc("late_jump", 1'b0, V_JUMP);
        check_eq("late_retired", retired, 32'd11);

        // 15 idle cycles in FETCH: timeout into HALT
        for (int w = 0; w < 15; w++) cyc($sformatf("to_w%0d", w), 1'b0, V_FETCH_W);
        check_eq("to_bus_err", {31'd0, bus_err}, 32'd1);
        cyc("halt_idle0", 1'b1, V_IDLE);
        cyc("halt_idle1", 1'b0, V_IDLE);
        check_eq("halt_bus_err", {31'd0, bus_err}, 32'd1);
        check_eq("halt_retired", retired, 32'd11);

        // Reset clears HALT and bus_err
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("rst2_bus_err", {31'd0, bus_err}, 32'd0);
        check_eq("rst2_retired", retired, 32'd0);
        cyc("rst2_fetch", 1'b0, V_FETCH_W);

        // One j to make retired non-zero, then reset in the middle of sw
        opcode = 6'h02;
        cyc("j2_fetch", 1'b1, V_FETCH_R);
        cyc("j2_dec", 1'b0, V_DEC);
        cyc("j2_jump", 1'b0, V_JUMP);
        check_eq("j2_retired", retired, 32'd1);
        opcode = 6'h2B;
        cyc("sw2_fetch", 1'b1, V_FETCH_R);
        cyc("sw2_dec", 1'b0, V_DEC);
        cyc("sw2_addr", 1'b0, V_MADDR);
        cyc("sw2_wr", 1'b0, V_MWR);
        mem_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("sw2_rst_mem_write", {31'd0, mem_write}, 32'd0);
        check_eq("sw2_rst_retired", retired, 32'd0);
        cyc("sw2_rst_fetch", 1'b0, V_FETCH_W);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run can never hang
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
